// File: rtl/std_cache_pkg.sv
// Shared dcache types and geometry for the SRAM arbiter.
// Index/line widths and the arbiter FSM state encoding.
package std_cache_pkg;

    localparam int DCACHE_INDEX_WIDTH = 8;
    localparam int DCACHE_LINE_WIDTH  = 128;

    typedef enum logic {
        INIT,
        RUN
    } arb_state_e;

endpackage

// File: rtl/rr_arb_core.sv
// Rotate-priority picker over ports 1..NR_PORTS-1.
// Port 0 never wins here; it is handled by the caller.
module rr_arb_core #(
    parameter int NR_PORTS = 4,
    parameter int PTR_W    = $clog2(NR_PORTS)
) (
    input  logic [NR_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]    i_ptr,
    output logic [NR_PORTS-1:0] o_gnt,
    output logic [PTR_W-1:0]    o_idx,
    output logic                o_valid
);

    // Scan from i_ptr upward, wrapping NR_PORTS-1 back to 1.
    always_comb begin
        int w_p;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_p     = 1;
        for (int k = 0; k < NR_PORTS - 1; k++) begin
            w_p = ((int'(i_ptr) - 1 + k) % (NR_PORTS - 1)) + 1;
            if (!o_valid && i_req[w_p]) begin
                o_valid    = 1'b1;
                o_gnt[w_p] = 1'b1;
                o_idx      = PTR_W'(w_p);
            end
        end
    end

endmodule

// File: rtl/dcache_sram_arb.sv
// Single-port dcache SRAM arbiter: port 0 fixed priority, others
// round-robin with starvation bound, plus the invalidation sweep.
module dcache_sram_arb
    import std_cache_pkg::*;
#(
    parameter int NR_PORTS     = 4,
    parameter int ADDR_WIDTH   = DCACHE_INDEX_WIDTH,
    parameter int DATA_WIDTH   = DCACHE_LINE_WIDTH,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic [NR_PORTS-1:0]            req_i,
    input  logic [NR_PORTS-1:0]            we_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i,
    output logic [NR_PORTS-1:0]            gnt_o,
    output logic [NR_PORTS-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           init_busy_o,
    output logic                           sram_req_o,
    output logic                           sram_we_o,
    output logic [ADDR_WIDTH-1:0]          sram_addr_o,
    output logic [DATA_WIDTH-1:0]          sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        sram_be_o,
    input  logic [DATA_WIDTH-1:0]          sram_rdata_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(NR_PORTS);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [PTR_W-1:0]        r_rr_ptr;
    logic [CNT_W-1:0]        r_starve;
    logic [NR_PORTS-1:0]     r_rvalid;

    logic [NR_PORTS-1:0]     w_rr_gnt;
    logic [PTR_W-1:0]        w_rr_idx;
    logic                    w_rr_valid;
    logic                    w_rr_any;
    logic                    w_rr_won;
    logic [NR_PORTS-1:0]     w_gnt;
    logic [PTR_W-1:0]        w_sel;

    assign w_rr_any = |req_i[NR_PORTS-1:1];
    assign w_rr_won = |w_gnt[NR_PORTS-1:1];

    rr_arb_core #(
        .NR_PORTS (NR_PORTS),
        .PTR_W    (PTR_W)
    ) u_rr (
        .i_req   ({req_i[NR_PORTS-1:1], 1'b0}),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_rr_gnt),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    // Next state, grant selection and SRAM port mux.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt        = '0;
        w_sel        = '0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        unique case (r_state)
            INIT: begin
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = r_idx;
                sram_be_o   = '1;
                if (r_idx == '1) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_rr_valid && r_starve == CNT_W'(STARVE_LIMIT)) begin
                    w_gnt = w_rr_gnt;
                    w_sel = w_rr_idx;
                end else if (req_i[0]) begin
                    w_gnt[0] = 1'b1;
                end else if (w_rr_valid) begin
                    w_gnt = w_rr_gnt;
                    w_sel = w_rr_idx;
                end
                sram_req_o   = |w_gnt;
                sram_we_o    = we_i[w_sel];
                sram_addr_o  = addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
                sram_wdata_o = wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
                sram_be_o    = be_i[w_sel*BE_W +: BE_W];
            end
            default: w_state_nxt = INIT;
        endcase
        if (clr_i) begin
            w_state_nxt = INIT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= INIT;
        else         r_state <= w_state_nxt;
    end

    // Sweep index: counts while sweeping, restarts on clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)              r_idx <= '0;
        else if (clr_i)           r_idx <= '0;
        else if (r_state == INIT) r_idx <= r_idx + 1'b1;
    end

    // Round-robin pointer and starvation counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= PTR_W'(1);
            r_starve <= '0;
        end else if (clr_i) begin
            r_rr_ptr <= PTR_W'(1);
            r_starve <= '0;
        end else if (r_state == RUN) begin
            if (w_rr_won) begin
                r_rr_ptr <= (w_sel == PTR_W'(NR_PORTS - 1)) ?
                            PTR_W'(1) : w_sel + 1'b1;
                r_starve <= '0;
            end else if (w_gnt[0] && w_rr_any) begin
                if (r_starve != CNT_W'(STARVE_LIMIT))
                    r_starve <= r_starve + 1'b1;
            end else begin
                r_starve <= '0;
            end
        end
    end

    // Read-valid pipeline: one cycle behind a read grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    r_rvalid <= '0;
        else if (clr_i) r_rvalid <= '0;
        else            r_rvalid <= w_gnt & ~we_i;
    end

    assign gnt_o       = w_gnt;
    assign rvalid_o    = r_rvalid;
    assign rdata_o     = sram_rdata_i;
    assign init_busy_o = (r_state == INIT);

endmodule

// File: tb/tb_dcache_sram_arb.sv
// Self-checking bench for dcache_sram_arb (4 ports, 8-entry SRAM).
// Directed scenarios plus a randomized run against a reference model.
module tb_dcache_sram_arb;

    localparam int NP = 4;
    localparam int AW = 3;
    localparam int DW = 128;
    localparam int BW = DW / 8;
    localparam int SL = 8;
    localparam int NW = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic [NP-1:0]    req = '0;
    logic [NP-1:0]    we = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NP*DW-1:0] wdata = '0;
    logic [NP*BW-1:0] be = '0;
    logic [NP-1:0]    gnt;
    logic [NP-1:0]    rvalid;
    logic [DW-1:0]    rdata;
    logic             init_busy;
    logic             sram_req;
    logic             sram_we;
    logic [AW-1:0]    sram_addr;
    logic [DW-1:0]    sram_wdata;
    logic [BW-1:0]    sram_be;
    logic [DW-1:0]    sram_rdata = '0;

    logic             pre_we = 1'b0;
    logic [AW-1:0]    pre_a = '0;
    logic [DW-1:0]    pre_d = '0;
    logic [DW-1:0]    mem [NW];

    int n_pass = 0;
    int n_tot  = 0;

    int            m_ptr;
    int            m_starve;
    int            m_init;
    logic [NP-1:0] m_rv;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [NW];

    dcache_sram_arb #(
        .NR_PORTS     (NP),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .be_i         (be),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .init_busy_o  (init_busy),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(
        input logic [DW-1:0] old_d,
        input logic [DW-1:0] new_d,
        input logic [BW-1:0] m
    );
        logic [DW-1:0] r;
        r = old_d;
        for (int b = 0; b < BW; b++)
            if (m[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_a] <= pre_d;
        else if (sram_req && sram_we)
            mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_be);
        else if (sram_req)
            sram_rdata <= mem[sram_addr];
    end

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NP-1:0] onehot(input int g);
        logic [NP-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Expected grant: -1 none, 0 priority port, 1..3 round-robin ports.
    function automatic int exp_grant();
        int win;
        win = -1;
        if (m_init > 0) return -1;
        for (int k = 0; k < NP - 1; k++) begin
            int p;
            p = ((m_ptr - 1 + k) % (NP - 1)) + 1;
            if (win < 0 && req[p]) win = p;
        end
        if (win > 0 && m_starve == SL) return win;
        if (req[0]) return 0;
        return win;
    endfunction

    task automatic model_reset();
        m_ptr    = 1;
        m_starve = 0;
        m_rv     = '0;
        m_rdata  = '0;
        m_init   = NW;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    endtask

    task automatic model_commit(input int g);
        logic [AW-1:0] a;
        if (clr) begin
            model_reset();
            return;
        end
        if (m_init > 0) begin
            m_init--;
            m_rv = '0;
            return;
        end
        m_rv = '0;
        if (g >= 0) begin
            a = addr[g*AW +: AW];
            if (we[g]) begin
                ref_mem[a] = merge(ref_mem[a], wdata[g*DW +: DW], be[g*BW +: BW]);
            end else begin
                m_rv[g] = 1'b1;
                m_rdata = ref_mem[a];
            end
        end
        if (g > 0) begin
            m_ptr    = (g == NP - 1) ? 1 : g + 1;
            m_starve = 0;
        end else if (g == 0 && |req[NP-1:1]) begin
            m_starve = (m_starve < SL) ? m_starve + 1 : SL;
        end else begin
            m_starve = 0;
        end
    endtask

    task automatic do_reset();
        req = '0; we = '0; clr = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        repeat (NW) @(posedge clk);
        #1;
        m_init = 0;
    endtask

    task automatic preload();
        for (int a = 0; a < NW; a++) begin
            pre_we = 1'b1;
            pre_a  = AW'(a);
            pre_d  = rnd128();
            ref_mem[a] = pre_d;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        req = '0; we = '0; clr = 1'b0;
        rst_n = 1'b0;
        #2;
        n_tot++;
        if (init_busy !== 1'b1 || gnt !== '0 || rvalid !== '0)
            $display("FAIL reset_state: busy=%b gnt=%b rv=%b want 1/0/0",
                     init_busy, gnt, rvalid);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) begin
            #3;
            n_tot++;
            if (sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== AW'(i) ||
                sram_wdata !== '0 || sram_be !== '1 || gnt !== '0 ||
                init_busy !== 1'b1)
                $display("FAIL sweep_%0d: req=%b we=%b addr=%0d be=%h gnt=%b want addr %0d",
                         i, sram_req, sram_we, sram_addr, sram_be, gnt, i);
            else n_pass++;
            @(posedge clk); #1;
        end
        #3;
        n_tot++;
        if (init_busy !== 1'b0 || sram_req !== 1'b0)
            $display("FAIL sweep_end: busy=%b sram_req=%b want 0/0",
                     init_busy, sram_req);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_rr_reads();
        int pg;
        logic [AW-1:0] pa;
        do_reset();
        preload();
        pg = -1;
        pa = '0;
        req = 4'b1110; we = '0;
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < NP; p++) addr[p*AW +: AW] = AW'($urandom_range(0, NW - 1));
            #4;
            n_tot++;
            if (gnt !== onehot((i % 3) + 1))
                $display("FAIL rr_gnt_%0d: got %b want %b", i, gnt, onehot((i % 3) + 1));
            else n_pass++;
            n_tot++;
            if (rvalid !== onehot(pg))
                $display("FAIL rr_rvalid_%0d: got %b want %b", i, rvalid, onehot(pg));
            else n_pass++;
            if (pg >= 0) begin
                n_tot++;
                if (rdata !== ref_mem[pa])
                    $display("FAIL rr_rdata_%0d: got %h want %h", i, rdata, ref_mem[pa]);
                else n_pass++;
            end
            pg = (i % 3) + 1;
            pa = addr[pg*AW +: AW];
            @(posedge clk); #1;
        end
        req = '0;
    endtask

    task automatic test_starve();
        int want;
        do_reset();
        req = 4'b0101; we = '0;
        for (int i = 0; i < 27; i++) begin
            want = (i % (SL + 1) < SL) ? 0 : 2;
            #4;
            n_tot++;
            if (gnt !== onehot(want))
                $display("FAIL starve_%0d: got %b want %b", i, gnt, onehot(want));
            else n_pass++;
            @(posedge clk); #1;
        end
        req = '0;
    endtask

    task automatic test_wr_rd();
        logic [DW-1:0] v;
        v = {16{8'hA5}};
        do_reset();
        req = 4'b0010; we = 4'b0010;
        addr[1*AW +: AW] = 3'd5;
        wdata[1*DW +: DW] = v;
        be[1*BW +: BW] = '1;
        #4;
        n_tot++;
        if (gnt !== 4'b0010 || sram_we !== 1'b1 || sram_addr !== 3'd5)
            $display("FAIL wr_gnt: gnt=%b we=%b addr=%0d want 0010/1/5",
                     gnt, sram_we, sram_addr);
        else n_pass++;
        @(posedge clk); #1;
        req = 4'b1000; we = '0;
        addr[3*AW +: AW] = 3'd5;
        #4;
        n_tot++;
        if (gnt !== 4'b1000 || rvalid !== '0)
            $display("FAIL rd_gnt: gnt=%b rv=%b want 1000/0000", gnt, rvalid);
        else n_pass++;
        @(posedge clk); #1;
        req = '0;
        #4;
        n_tot++;
        if (rvalid !== 4'b1000 || rdata !== v)
            $display("FAIL wr_rd_data: rv=%b data=%h want 1000/%h", rvalid, rdata, v);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_clr();
        do_reset();
        req = 4'b0010; we = '0;
        addr[1*AW +: AW] = 3'd2;
        clr = 1'b1;
        #4;
        n_tot++;
        if (gnt !== 4'b0010 || sram_req !== 1'b1 || sram_addr !== 3'd2)
            $display("FAIL clr_gnt: gnt=%b req=%b addr=%0d want 0010/1/2",
                     gnt, sram_req, sram_addr);
        else n_pass++;
        @(posedge clk); #1;
        clr = 1'b0;
        #4;
        n_tot++;
        if (rvalid !== '0 || init_busy !== 1'b1 || gnt !== '0 ||
            sram_addr !== '0 || sram_we !== 1'b1)
            $display("FAIL clr_sweep: rv=%b busy=%b gnt=%b addr=%0d we=%b want 0/1/0/0/1",
                     rvalid, init_busy, gnt, sram_addr, sram_we);
        else n_pass++;
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic test_rst_mid();
        req = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = 4'b1111; we = '0;
        repeat (4) @(posedge clk);
        #3;
        n_tot++;
        if (sram_addr !== 3'd4 || gnt !== '0)
            $display("FAIL mid_pre: addr=%0d gnt=%b want 4/0000", sram_addr, gnt);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_tot++;
        if (sram_addr !== '0 || init_busy !== 1'b1 || gnt !== '0 || rvalid !== '0)
            $display("FAIL mid_rst: addr=%0d busy=%b gnt=%b rv=%b want 0/1/0/0",
                     sram_addr, init_busy, gnt, rvalid);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) begin
            #3;
            n_tot++;
            if (sram_addr !== AW'(i) || gnt !== '0 || init_busy !== 1'b1)
                $display("FAIL mid_sweep_%0d: addr=%0d gnt=%b busy=%b want %0d/0000/1",
                         i, sram_addr, gnt, init_busy, i);
            else n_pass++;
            @(posedge clk); #1;
        end
        #3;
        n_tot++;
        if (gnt !== 4'b0001 || init_busy !== 1'b0)
            $display("FAIL mid_first_gnt: gnt=%b busy=%b want 0001/0", gnt, init_busy);
        else n_pass++;
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req   = NP'($urandom);
            we    = NP'($urandom);
            addr  = NP*AW'($urandom);
            wdata = {rnd128(), rnd128(), rnd128(), rnd128()};
            be    = {$urandom, $urandom};
            clr   = ($urandom_range(0, 59) == 0);
            #4;
            g = exp_grant();
            n_tot++;
            if (gnt !== onehot(g))
                $display("FAIL rnd_gnt_%0d: got %b want %b", i, gnt, onehot(g));
            else n_pass++;
            n_tot++;
            if (rvalid !== m_rv)
                $display("FAIL rnd_rvalid_%0d: got %b want %b", i, rvalid, m_rv);
            else n_pass++;
            if (m_rv != '0) begin
                n_tot++;
                if (rdata !== m_rdata)
                    $display("FAIL rnd_rdata_%0d: got %h want %h", i, rdata, m_rdata);
                else n_pass++;
            end
            if (g >= 0) begin
                n_tot++;
                if (sram_req !== 1'b1 || sram_we !== we[g] ||
                    sram_addr !== addr[g*AW +: AW])
                    $display("FAIL rnd_sram_%0d: req=%b we=%b addr=%0d want 1/%b/%0d",
                             i, sram_req, sram_we, sram_addr, we[g], addr[g*AW +: AW]);
                else n_pass++;
            end
            model_commit(g);
            @(posedge clk); #1;
        end
        req = '0; clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rr_reads();
        test_starve();
        test_wr_rd();
        test_clr();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
